// File: rtl/gshare_predictor.sv
// gshare direction predictor: PC xor global history indexes a table of 2-bit
// saturating counters; execute trains the counters and repairs the history.
module gshare_predictor #(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 8,
    parameter int HIST_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lookup_valid,
    input  logic [PC_WIDTH-1:0]   lookup_pc,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_index,
    output logic [HIST_BITS-1:0]  pred_ghr,
    input  logic                  update_valid,
    input  logic [INDEX_BITS-1:0] update_index,
    input  logic [HIST_BITS-1:0]  update_ghr,
    input  logic                  update_taken,
    input  logic                  update_mispredict,
    output logic [31:0]           branch_count,
    output logic [31:0]           mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [1:0]           counters [ENTRIES];
    logic [HIST_BITS-1:0] ghr;
    logic [1:0]           next_counter;
    logic                 repair;
    logic                 unused_bits;

    assign unused_bits = ^{lookup_pc[PC_WIDTH-1:INDEX_BITS+2], lookup_pc[1:0],
                           update_ghr[HIST_BITS-1]};

    assign pred_index = lookup_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr);
    assign pred_taken = counters[pred_index][1];
    assign pred_ghr   = ghr;
    assign repair     = update_valid & update_mispredict;

    always_comb begin
        next_counter = counters[update_index];
        case (counters[update_index])
            2'b00:   next_counter = update_taken ? 2'b01 : 2'b00;
            2'b01:   next_counter = update_taken ? 2'b10 : 2'b00;
            2'b10:   next_counter = update_taken ? 2'b11 : 2'b01;
            default: next_counter = update_taken ? 2'b11 : 2'b10;
        endcase
    end

    // Lookups read the table combinationally, so a same-cycle update is not bypassed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                counters[i] <= 2'b01;
            end
        end else if (update_valid) begin
            counters[update_index] <= next_counter;
        end
    end

    // A mispredict repair wins over the speculative shift of a flushed lookup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (repair) begin
            ghr <= {update_ghr[HIST_BITS-2:0], update_taken};
        end else if (lookup_valid) begin
            ghr <= {ghr[HIST_BITS-2:0], pred_taken};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (update_valid && branch_count != 32'hFFFF_FFFF) begin
                branch_count <= branch_count + 32'd1;
            end
            if (repair && mispredict_count != 32'hFFFF_FFFF) begin
                mispredict_count <= mispredict_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed self-checking bench for gshare_predictor: inputs change on the
// falling edge and outputs are sampled 1ns later, well away from the rising edge.
module tb_gshare_predictor;

    logic        clk;
    logic        rst_n;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        pred_taken;
    logic [7:0]  pred_index;
    logic [7:0]  pred_ghr;
    logic        update_valid;
    logic [7:0]  update_index;
    logic [7:0]  update_ghr;
    logic        update_taken;
    logic        update_mispredict;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int          vectors;
    int          miscompares;
    logic [7:0]  exp_ghr;

    gshare_predictor #(.PC_WIDTH(32), .INDEX_BITS(8), .HIST_BITS(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .lookup_valid      (lookup_valid),
        .lookup_pc         (lookup_pc),
        .pred_taken        (pred_taken),
        .pred_index        (pred_index),
        .pred_ghr          (pred_ghr),
        .update_valid      (update_valid),
        .update_index      (update_index),
        .update_ghr        (update_ghr),
        .update_taken      (update_taken),
        .update_mispredict (update_mispredict),
        .branch_count      (branch_count),
        .mispredict_count  (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC whose index bits xor the model history to land on the wanted entry.
    function automatic logic [31:0] pc_for(input logic [7:0] idx);
        return {22'd0, idx ^ exp_ghr, 2'b00};
    endfunction

    task automatic idle_inputs();
        lookup_valid      = 1'b0;
        lookup_pc         = 32'd0;
        update_valid      = 1'b0;
        update_index      = 8'd0;
        update_ghr        = 8'd0;
        update_taken      = 1'b0;
        update_mispredict = 1'b0;
    endtask

    task automatic drive_update(input logic [7:0] idx, input logic taken,
                                input logic mp, input logic [7:0] ghr_in);
        @(negedge clk);
        idle_inputs();
        update_valid      = 1'b1;
        update_index      = idx;
        update_taken      = taken;
        update_mispredict = mp;
        update_ghr        = ghr_in;
        #1;
    endtask

    task automatic drive_lookup(input logic [7:0] idx);
        @(negedge clk);
        idle_inputs();
        lookup_valid = 1'b1;
        lookup_pc    = pc_for(idx);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        lookup_valid = 1'b1;
        lookup_pc    = 32'h0000_0100;
        #1;
        vectors++;
        if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
            $display("[TB] FAIL reset_counts: got %0d/%0d, want 0/0", branch_count, mispredict_count);
            miscompares++;
        end
        vectors++;
        if (pred_ghr !== 8'h00 || pred_taken !== 1'b0) begin
            $display("[TB] FAIL reset_pred: got ghr=%h taken=%b, want ghr=00 taken=0", pred_ghr, pred_taken);
            miscompares++;
        end
        lookup_pc = 32'h0000_03FC;
        #1;
        vectors++;
        if (pred_taken !== 1'b0) begin
            $display("[TB] FAIL reset_pred_ff: got taken=%b, want 0", pred_taken);
            miscompares++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        exp_ghr = 8'h00;
    endtask

    task automatic test_lookup_basic();
        @(negedge clk);
        lookup_valid = 1'b1;
        lookup_pc    = 32'h0000_0100;
        #1;
        vectors++;
        if (pred_index !== 8'h40 || pred_ghr !== 8'h00 || pred_taken !== 1'b0) begin
            $display("[TB] FAIL lookup_basic: got idx=%h ghr=%h taken=%b, want idx=40 ghr=00 taken=0",
                     pred_index, pred_ghr, pred_taken);
            miscompares++;
        end
        exp_ghr = {exp_ghr[6:0], 1'b0};
        drive_lookup(8'h40);
        vectors++;
        if (pred_ghr !== 8'h00 || pred_index !== 8'h40) begin
            $display("[TB] FAIL lookup_shift0: got ghr=%h idx=%h, want ghr=00 idx=40", pred_ghr, pred_index);
            miscompares++;
        end
        exp_ghr = {exp_ghr[6:0], 1'b0};
    endtask

    task automatic test_train_taken();
        drive_update(8'h40, 1'b1, 1'b0, 8'h00);
        drive_update(8'h40, 1'b1, 1'b0, 8'h00);
        drive_lookup(8'h40);
        vectors++;
        if (pred_taken !== 1'b1 || pred_ghr !== 8'h00) begin
            $display("[TB] FAIL train_taken: got taken=%b ghr=%h, want taken=1 ghr=00", pred_taken, pred_ghr);
            miscompares++;
        end
        exp_ghr = {exp_ghr[6:0], 1'b1};
        drive_update(8'h40, 1'b1, 1'b0, 8'h00);
        drive_update(8'h40, 1'b1, 1'b0, 8'h00);
        drive_lookup(8'h40);
        vectors++;
        if (pred_taken !== 1'b1 || pred_ghr !== 8'h01 || pred_index !== 8'h40) begin
            $display("[TB] FAIL train_saturate: got taken=%b ghr=%h idx=%h, want taken=1 ghr=01 idx=40",
                     pred_taken, pred_ghr, pred_index);
            miscompares++;
        end
        exp_ghr = {exp_ghr[6:0], 1'b1};
    endtask

    task automatic test_train_not_taken();
        logic [3:0] want;
        want = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            drive_update(8'h40, 1'b0, 1'b0, 8'h00);
            drive_lookup(8'h40);
            vectors++;
            if (pred_taken !== want[i] || pred_ghr !== exp_ghr) begin
                $display("[TB] FAIL train_not_taken[%0d]: got taken=%b ghr=%h, want taken=%b ghr=%h",
                         i, pred_taken, pred_ghr, want[i], exp_ghr);
                miscompares++;
            end
            exp_ghr = {exp_ghr[6:0], want[i]};
        end
        vectors++;
        if (branch_count !== 32'd8 || mispredict_count !== 32'd0) begin
            $display("[TB] FAIL count_after_train: got %0d/%0d, want 8/0", branch_count, mispredict_count);
            miscompares++;
        end
    endtask

    task automatic test_repair_priority();
        drive_update(8'h10, 1'b1, 1'b0, 8'h00);
        drive_lookup(8'h10);
        update_valid      = 1'b1;
        update_index      = 8'h20;
        update_ghr        = 8'h5A;
        update_taken      = 1'b1;
        update_mispredict = 1'b1;
        #1;
        vectors++;
        if (pred_taken !== 1'b1) begin
            $display("[TB] FAIL repair_lookup_pred: got taken=%b, want 1", pred_taken);
            miscompares++;
        end
        exp_ghr = 8'hB5;
        drive_lookup(8'h20);
        vectors++;
        if (pred_ghr !== 8'hB5 || pred_taken !== 1'b1) begin
            $display("[TB] FAIL repair_ghr: got ghr=%h taken=%b, want ghr=b5 taken=1", pred_ghr, pred_taken);
            miscompares++;
        end
        exp_ghr = {exp_ghr[6:0], 1'b1};
        vectors++;
        if (branch_count !== 32'd10 || mispredict_count !== 32'd1) begin
            $display("[TB] FAIL count_after_repair: got %0d/%0d, want 10/1", branch_count, mispredict_count);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        drive_update(8'h40, 1'b1, 1'b0, 8'h00);
        drive_lookup(8'h40);
        update_valid = 1'b1;
        update_index = 8'h40;
        update_taken = 1'b1;
        #1;
        vectors++;
        if (pred_taken !== 1'b0 || pred_index !== 8'h40) begin
            $display("[TB] FAIL same_cycle_old: got taken=%b idx=%h, want taken=0 idx=40", pred_taken, pred_index);
            miscompares++;
        end
        exp_ghr = {exp_ghr[6:0], 1'b0};
        drive_lookup(8'h40);
        vectors++;
        if (pred_taken !== 1'b1 || pred_ghr !== exp_ghr) begin
            $display("[TB] FAIL same_cycle_new: got taken=%b ghr=%h, want taken=1 ghr=%h",
                     pred_taken, pred_ghr, exp_ghr);
            miscompares++;
        end
        exp_ghr = {exp_ghr[6:0], 1'b1};
    endtask

    task automatic test_counts_and_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n   = 1'b1;
        exp_ghr = 8'h00;
        drive_update(8'h33, 1'b1, 1'b0, 8'h00);
        drive_update(8'h33, 1'b1, 1'b0, 8'h00);
        drive_update(8'h33, 1'b1, 1'b1, 8'h00);
        exp_ghr = 8'h01;
        @(negedge clk);
        idle_inputs();
        update_mispredict = 1'b1;
        update_ghr        = 8'hFF;
        update_taken      = 1'b1;
        drive_lookup(8'h33);
        vectors++;
        if (pred_taken !== 1'b1 || pred_ghr !== 8'h01) begin
            $display("[TB] FAIL pre_reset_pred: got taken=%b ghr=%h, want taken=1 ghr=01", pred_taken, pred_ghr);
            miscompares++;
        end
        vectors++;
        if (branch_count !== 32'd3 || mispredict_count !== 32'd1) begin
            $display("[TB] FAIL pre_reset_counts: got %0d/%0d, want 3/1", branch_count, mispredict_count);
            miscompares++;
        end
        @(negedge clk);
        idle_inputs();
        update_valid      = 1'b1;
        update_index      = 8'h33;
        update_taken      = 1'b1;
        update_mispredict = 1'b1;
        update_ghr        = 8'hA5;
        #2;
        rst_n   = 1'b0;
        exp_ghr = 8'h00;
        lookup_valid = 1'b1;
        lookup_pc    = pc_for(8'h33);
        #1;
        vectors++;
        if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
            $display("[TB] FAIL async_reset_counts: got %0d/%0d, want 0/0", branch_count, mispredict_count);
            miscompares++;
        end
        vectors++;
        if (pred_taken !== 1'b0 || pred_ghr !== 8'h00 || pred_index !== 8'h33) begin
            $display("[TB] FAIL async_reset_pred: got taken=%b ghr=%h idx=%h, want taken=0 ghr=00 idx=33",
                     pred_taken, pred_ghr, pred_index);
            miscompares++;
        end
        lookup_pc = 32'h0000_0100;
        #1;
        vectors++;
        if (pred_taken !== 1'b0) begin
            $display("[TB] FAIL async_reset_entry40: got taken=%b, want 0", pred_taken);
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (branch_count !== 32'd0 || mispredict_count !== 32'd0 || pred_ghr !== 8'h00) begin
            $display("[TB] FAIL reset_held: got %0d/%0d ghr=%h, want 0/0 ghr=00",
                     branch_count, mispredict_count, pred_ghr);
            miscompares++;
        end
        rst_n = 1'b1;
        idle_inputs();
        drive_lookup(8'h33);
        vectors++;
        if (pred_taken !== 1'b0 || pred_ghr !== 8'h00) begin
            $display("[TB] FAIL post_reset_entry33: got taken=%b ghr=%h, want taken=0 ghr=00", pred_taken, pred_ghr);
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_ghr     = 8'h00;
        test_reset();
        test_lookup_basic();
        test_train_taken();
        test_train_not_taken();
        test_repair_priority();
        test_back_to_back();
        test_counts_and_reset();
        @(negedge clk);
        idle_inputs();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
